// File: rtl/bp_pkg.sv
// Shared defaults, constants and entry layout for the branch predictor.
package bp_pkg;

    localparam int DEFAULT_XLEN     = 64;
    localparam int DEFAULT_ENTRIES  = 16;
    localparam int DEFAULT_CTR_BITS = 2;
    localparam int PC_INC           = 4;

    localparam int DEFAULT_IDX_W = $clog2(DEFAULT_ENTRIES);
    localparam int DEFAULT_TAG_W = DEFAULT_XLEN - DEFAULT_IDX_W - 2;

    // Entry layout at the default geometry; the top re-declares it with its own widths.
    typedef struct packed {
        logic                        valid;
        logic [DEFAULT_TAG_W-1:0]    tag;
        logic [DEFAULT_CTR_BITS-1:0] ctr;
        logic [DEFAULT_XLEN-1:0]     target;
    } bp_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with a parallel load; resets to weakly not-taken.
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    input  logic [CTR_BITS-1:0] load_value,
    output logic [CTR_BITS-1:0] count
);

    localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE   = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CTR_RESET;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            if (count != CTR_MAX) begin
                count <= count + CTR_ONE;
            end
        end else if (dec) begin
            if (count != '0) begin
                count <= count - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int ENTRIES  = DEFAULT_ENTRIES,
    parameter int CTR_BITS = DEFAULT_CTR_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_pred_taken,
    output logic            mispredict,
    input  logic            bp_clear,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [31:0] CNT_MAX = '1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

    entry_t              table_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr     [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [TAG_W-1:0] update_tag;
    logic             update_hit;
    logic             update_commit;
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispredict_cnt_q;
    logic             unused_pc_bits;

    // Instructions are word aligned, so the two low PC bits carry no information.
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign lookup_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign update_idx = update_pc[IDX_W+1:2];
    assign update_tag = update_pc[XLEN-1:IDX_W+2];

    assign update_hit    = table_q[update_idx].valid && (table_q[update_idx].tag == update_tag);
    assign update_commit = update_valid && !bp_clear;

    assign pred_hit    = !reset && table_q[lookup_idx].valid && (table_q[lookup_idx].tag == lookup_tag);
    assign pred_taken  = pred_hit && ctr[lookup_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? table_q[lookup_idx].target : lookup_pc + XLEN'(PC_INC);
    assign mispredict  = update_valid && (update_pred_taken != update_taken);

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    // A clear suppresses the update entirely, so counters only move on a committed update.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        logic sel;
        assign sel = update_commit && (update_idx == IDX_W'(i));

        sat_counter #(
            .CTR_BITS(CTR_BITS)
        ) u_ctr (
            .clk       (clk),
            .reset     (reset),
            .inc       (sel && update_hit && update_taken),
            .dec       (sel && update_hit && !update_taken),
            .load      (sel && !update_hit && update_taken),
            .load_value(CTR_WEAK_TAKEN),
            .count     (ctr[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (update_valid && update_taken) begin
            // A taken outcome always refreshes the target; a miss also claims the slot.
            table_q[update_idx].target <= update_target;
            if (!update_hit) begin
                table_q[update_idx].valid <= 1'b1;
                table_q[update_idx].tag   <= update_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (update_valid && (branch_cnt_q != CNT_MAX)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict && (mispredict_cnt_q != CNT_MAX)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic vs. a table model.
module tb_branch_predictor;

    localparam int XLEN    = 64;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] lookup_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic            update_taken;
    logic [XLEN-1:0] update_target;
    logic            update_pred_taken;
    logic            mispredict;
    logic            bp_clear;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispredict_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain arrays indexed by slot number, counter kept as an integer 0..3.
    bit              m_valid  [ENTRIES];
    logic [XLEN-1:0] m_tag    [ENTRIES];
    int              m_ctr    [ENTRIES];
    logic [XLEN-1:0] m_target [ENTRIES];
    logic [31:0]     m_branches;
    logic [31:0]     m_mispredicts;

    logic            exp_hit;
    logic            exp_taken;
    logic [XLEN-1:0] exp_target;
    logic            exp_mis;

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CTR_BITS(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .update_pred_taken(update_pred_taken),
        .mispredict       (mispredict),
        .bp_clear         (bp_clear),
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 clk = ~clk;

    function automatic int slot_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_ctr[i]    = 1;
            m_target[i] = '0;
        end
        m_branches    = '0;
        m_mispredicts = '0;
    endtask

    task automatic model_predict(input logic [XLEN-1:0] pc);
        int s;
        s          = slot_of(pc);
        exp_hit    = m_valid[s] && (m_tag[s] == tag_of(pc));
        exp_taken  = exp_hit && (m_ctr[s] >= 2);
        exp_target = exp_taken ? m_target[s] : pc + 64'd4;
    endtask

    task automatic model_commit();
        int  s;
        bit  hit;
        s   = slot_of(update_pc);
        hit = m_valid[s] && (m_tag[s] == tag_of(update_pc));
        if (update_valid && m_branches != 32'hFFFF_FFFF) m_branches++;
        if (update_valid && (update_pred_taken != update_taken) && m_mispredicts != 32'hFFFF_FFFF)
            m_mispredicts++;
        if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (update_valid) begin
            if (hit) begin
                if (update_taken) begin
                    m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                    m_target[s] = update_target;
                end else begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end
            end else if (update_taken) begin
                m_valid[s]  = 1'b1;
                m_tag[s]    = tag_of(update_pc);
                m_target[s] = update_target;
                m_ctr[s]    = 2;
            end
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_update(input logic [XLEN-1:0] pc, input logic taken,
                              input logic [XLEN-1:0] target, input logic pred);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_target     = target;
        update_pred_taken = pred;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        lookup_pc         = '0;
        update_valid      = 1'b0;
        update_pc         = '0;
        update_taken      = 1'b0;
        update_target     = '0;
        update_pred_taken = 1'b0;
        bp_clear          = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        update_taken      = 1'b0;
        update_pred_taken = 1'b1;
        lookup_pc         = 64'h100;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_hit: got %0b expected 0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL reset_taken: got %0b expected 0", pred_taken); end
        checks++; if (pred_target !== 64'h104) begin failures++; $display("[TB] FAIL reset_target: got %h expected 104", pred_target); end
        checks++; if (branch_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_branch_cnt: got %0d expected 0", branch_cnt); end
        checks++; if (mispredict_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_mis_cnt: got %0d expected 0", mispredict_cnt); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("[TB] FAIL idle_mispredict: got %0b expected 0", mispredict); end
    endtask

    task automatic test_allocate();
        set_update(64'h100, 1'b1, 64'h40, 1'b0);
        lookup_pc = 64'h100;
        #1;
        checks++; if (mispredict !== 1'b1) begin failures++; $display("[TB] FAIL alloc_mispredict: got %0b expected 1", mispredict); end
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL alloc_no_bypass: got %0b expected 0", pred_hit); end
        tick();
        update_valid = 1'b0;
        #1;
        checks++; if (pred_hit !== 1'b1) begin failures++; $display("[TB] FAIL alloc_hit: got %0b expected 1", pred_hit); end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("[TB] FAIL alloc_taken: got %0b expected 1", pred_taken); end
        checks++; if (pred_target !== 64'h40) begin failures++; $display("[TB] FAIL alloc_target: got %h expected 40", pred_target); end
        checks++; if (mispredict_cnt !== 32'd1) begin failures++; $display("[TB] FAIL alloc_mis_cnt: got %0d expected 1", mispredict_cnt); end
        checks++; if (branch_cnt !== 32'd1) begin failures++; $display("[TB] FAIL alloc_branch_cnt: got %0d expected 1", branch_cnt); end
    endtask

    task automatic test_saturate_down();
        lookup_pc = 64'h100;
        for (int k = 0; k < 3; k++) begin
            set_update(64'h100, 1'b0, 64'h0, 1'b0);
            tick();
            update_valid = 1'b0;
            #1;
            checks++; if (pred_hit !== 1'b1) begin failures++; $display("[TB] FAIL dec%0d_hit: got %0b expected 1", k, pred_hit); end
            checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL dec%0d_taken: got %0b expected 0", k, pred_taken); end
            checks++; if (pred_target !== 64'h104) begin failures++; $display("[TB] FAIL dec%0d_target: got %h expected 104", k, pred_target); end
        end
        // Counter is now 0: one taken brings it to 1 (still not-taken), a second to 2.
        set_update(64'h100, 1'b1, 64'h80, 1'b0);
        tick();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL inc1_taken: got %0b expected 0", pred_taken); end
        tick();
        update_valid = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("[TB] FAIL inc2_taken: got %0b expected 1", pred_taken); end
        checks++; if (pred_target !== 64'h80) begin failures++; $display("[TB] FAIL inc2_target: got %h expected 80", pred_target); end
        checks++; if (branch_cnt !== 32'd6) begin failures++; $display("[TB] FAIL sat_branch_cnt: got %0d expected 6", branch_cnt); end
        checks++; if (mispredict_cnt !== 32'd3) begin failures++; $display("[TB] FAIL sat_mis_cnt: got %0d expected 3", mispredict_cnt); end
    endtask

    task automatic test_alias();
        set_update(64'h140, 1'b1, 64'h500, 1'b1);
        tick();
        set_update(64'h180, 1'b0, 64'h700, 1'b0);
        lookup_pc = 64'h100;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL alias_old_hit: got %0b expected 0", pred_hit); end
        checks++; if (pred_target !== 64'h104) begin failures++; $display("[TB] FAIL alias_old_target: got %h expected 104", pred_target); end
        tick();
        update_valid = 1'b0;
        lookup_pc    = 64'h140;
        #1;
        checks++; if (pred_hit !== 1'b1) begin failures++; $display("[TB] FAIL alias_new_hit: got %0b expected 1", pred_hit); end
        checks++; if (pred_target !== 64'h500) begin failures++; $display("[TB] FAIL alias_new_target: got %h expected 500", pred_target); end
        lookup_pc = 64'h180;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL nt_miss_alloc: got %0b expected 0", pred_hit); end
    endtask

    task automatic test_clear();
        set_update(64'h200, 1'b1, 64'h900, 1'b0);
        bp_clear = 1'b1;
        tick();
        bp_clear     = 1'b0;
        update_valid = 1'b0;
        lookup_pc    = 64'h200;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL clear_upd_hit: got %0b expected 0", pred_hit); end
        lookup_pc = 64'h140;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL clear_old_hit: got %0b expected 0", pred_hit); end
        checks++; if (branch_cnt !== 32'd9) begin failures++; $display("[TB] FAIL clear_branch_cnt: got %0d expected 9", branch_cnt); end
        checks++; if (mispredict_cnt !== 32'd4) begin failures++; $display("[TB] FAIL clear_mis_cnt: got %0d expected 4", mispredict_cnt); end
    endtask

    task automatic test_wrap();
        lookup_pc = '1;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL wrap_hit: got %0b expected 0", pred_hit); end
        checks++; if (pred_target !== 64'h3) begin failures++; $display("[TB] FAIL wrap_target: got %h expected 3", pred_target); end
    endtask

    task automatic test_reset_mid_update();
        set_update(64'h300, 1'b1, 64'hA00, 1'b0);
        tick();
        set_update(64'h340, 1'b1, 64'hB00, 1'b0);
        lookup_pc = 64'h300;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL inreset_hit: got %0b expected 0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL inreset_taken: got %0b expected 0", pred_taken); end
        checks++; if (pred_target !== 64'h304) begin failures++; $display("[TB] FAIL inreset_target: got %h expected 304", pred_target); end
        checks++; if (branch_cnt !== 32'd0) begin failures++; $display("[TB] FAIL inreset_branch_cnt: got %0d expected 0", branch_cnt); end
        @(posedge clk);
        #1;
        reset        = 1'b0;
        update_valid = 1'b0;
        lookup_pc    = 64'h340;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL discarded_update_hit: got %0b expected 0", pred_hit); end
        checks++; if (branch_cnt !== 32'd0) begin failures++; $display("[TB] FAIL discarded_branch_cnt: got %0d expected 0", branch_cnt); end
    endtask

    task automatic test_stat_saturation();
        force dut.branch_cnt_q     = 32'hFFFF_FFFE;
        force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.branch_cnt_q;
        release dut.mispredict_cnt_q;
        m_branches    = 32'hFFFF_FFFE;
        m_mispredicts = 32'hFFFF_FFFE;
        #1;
        checks++; if (branch_cnt !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL preload_branch_cnt: got %h expected fffffffe", branch_cnt); end
        for (int k = 0; k < 2; k++) begin
            set_update(64'h400, 1'b1, 64'hC00, 1'b0);
            bp_clear = (k == 1);
            tick();
            checks++; if (branch_cnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat%0d_branch_cnt: got %h expected ffffffff", k, branch_cnt); end
            checks++; if (mispredict_cnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat%0d_mis_cnt: got %h expected ffffffff", k, mispredict_cnt); end
        end
        bp_clear     = 1'b0;
        update_valid = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] rand_pc();
        logic [XLEN-1:0] tag;
        case ($urandom_range(0, 3))
            0:       tag = 64'h0;
            1:       tag = 64'h1;
            2:       tag = 64'h2;
            default: tag = 64'h03FF_FFFF_FFFF_FFFF;
        endcase
        return (tag << (2 + IDX_W)) | (64'($urandom_range(0, ENTRIES - 1)) << 2)
               | 64'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            update_valid      = ($urandom_range(0, 3) != 0);
            update_pc         = rand_pc();
            update_taken      = $urandom_range(0, 1) == 1;
            update_pred_taken = $urandom_range(0, 1) == 1;
            update_target     = {$urandom(), $urandom()};
            bp_clear          = ($urandom_range(0, 19) == 0);
            lookup_pc         = ($urandom_range(0, 1) == 1) ? update_pc : rand_pc();
            #1;
            model_predict(lookup_pc);
            exp_mis = update_valid && (update_pred_taken != update_taken);
            checks++; if (pred_hit !== exp_hit) begin failures++; $display("[TB] FAIL rnd%0d_hit: got %0b expected %0b", n, pred_hit, exp_hit); end
            checks++; if (pred_taken !== exp_taken) begin failures++; $display("[TB] FAIL rnd%0d_taken: got %0b expected %0b", n, pred_taken, exp_taken); end
            checks++; if (pred_target !== exp_target) begin failures++; $display("[TB] FAIL rnd%0d_target: got %h expected %h", n, pred_target, exp_target); end
            checks++; if (mispredict !== exp_mis) begin failures++; $display("[TB] FAIL rnd%0d_mispredict: got %0b expected %0b", n, mispredict, exp_mis); end
            checks++; if (branch_cnt !== m_branches) begin failures++; $display("[TB] FAIL rnd%0d_branch_cnt: got %0d expected %0d", n, branch_cnt, m_branches); end
            checks++; if (mispredict_cnt !== m_mispredicts) begin failures++; $display("[TB] FAIL rnd%0d_mis_cnt: got %0d expected %0d", n, mispredict_cnt, m_mispredicts); end
            tick();
        end
        update_valid = 1'b0;
        bp_clear     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturate_down();
        test_alias();
        test_clear();
        test_wrap();
        test_reset_mid_update();
        test_stat_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning PC/target width in bits.
REQ-002 The block SHALL have parameter ENTRIES, default 16, meaning table depth, a power of two and at least 2; IDX_W = log2(ENTRIES).
REQ-003 The block SHALL have parameter CTR_BITS, default 2, meaning saturating-counter width, at least 1.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- lookup_pc, in, XLEN, IF-stage PC.
- pred_hit, out, 1, lookup matched a valid entry.
- pred_taken, out, 1, predict taken.
- pred_target, out, XLEN, next-PC prediction.
- update_valid, in, 1, a branch resolved this cycle.
- update_pc, in, XLEN, PC of the resolved branch.
- update_taken, in, 1, actual outcome.
- update_target, in, XLEN, actual taken target.
- update_pred_taken, in, 1, prediction that was carried down the pipe.
- mispredict, out, 1, update_valid & (update_pred_taken != update_taken).
- bp_clear, in, 1, invalidate the whole table.
- branch_cnt, out, 32, resolved-branch count.
- mispredict_cnt, out, 32, misprediction count.

Function
REQ-006 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[XLEN-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-007 Each entry SHALL hold valid, tag, a CTR_BITS counter and an XLEN target.
REQ-008 Lookup SHALL be combinational with zero latency: pred_hit = valid & tag match; pred_taken = pred_hit & counter MSB.
REQ-009 pred_target SHALL be the stored target when pred_taken=1, else lookup_pc+4 (modulo 2^XLEN, wrapping).
REQ-010 mispredict SHALL be combinational and 0 whenever update_valid=0.
REQ-011 An update SHALL commit on the rising edge when update_valid=1; on an update hit the counter SHALL increment if taken and decrement if not taken, saturating at 2^CTR_BITS-1 and at 0.
REQ-012 On an update hit with update_taken=1 the stored target SHALL be overwritten with update_target.
REQ-013 On an update miss with update_taken=1 the entry SHALL be allocated (replacing any previous occupant): valid=1, new tag, target=update_target, counter=2^(CTR_BITS-1) (weakly taken).
REQ-014 On an update miss with update_taken=0 the table SHALL be unchanged.
REQ-015 There SHALL be no lookup/update bypass: a lookup in the same cycle as an update to the same index SHALL see the pre-edge contents.
REQ-016 bp_clear=1 SHALL clear every valid bit at the edge and SHALL take priority over a simultaneous update; counters and statistics SHALL be unaffected.
REQ-017 branch_cnt SHALL increment on each edge with update_valid=1, and mispredict_cnt on each edge with mispredict=1; both SHALL saturate at 32'hFFFFFFFF and SHALL still count when bp_clear=1.

Reset
REQ-018 Reset SHALL asynchronously clear every valid bit, set every counter to 2^(CTR_BITS-1)-1 (weakly not-taken), set every target to 0, and set branch_cnt and mispredict_cnt to 0.
REQ-019 During reset, outputs SHALL be pred_hit=0, pred_taken=0 and pred_target=lookup_pc+4; reset asserted mid-update SHALL discard that update.

Structure
REQ-020 The package bp_pkg SHALL hold the default XLEN/ENTRIES/CTR_BITS values, the PC increment constant 4 and the entry struct typedef.
REQ-021 The counter SHALL be a sub-module sat_counter, parametrised by CTR_BITS, with inc/dec/load inputs; the table SHALL be flip-flop based.

Verification
REQ-022 Reset, then lookup_pc=0x100: the bench SHALL see pred_hit=0, pred_taken=0, pred_target=0x104, branch_cnt=0.
REQ-023 Update pc=0x100, taken, target 0x40, update_pred_taken=0: the bench SHALL see mispredict=1 that cycle; the next-cycle lookup of 0x100 SHALL give hit=1, taken=1, target=0x40, and mispredict_cnt=1.
REQ-024 With that entry allocated (counter 2), send three not-taken updates for 0x100: the counter SHALL go 1, 0, 0 (saturating); lookup SHALL give hit=1, taken=0, target=0x104.
REQ-025 With ENTRIES=16, allocate 0x100 and then a taken update for 0x140 (same index, different tag): lookup 0x100 SHALL miss and lookup 0x140 SHALL hit.
REQ-026 Assert bp_clear together with a taken update for 0x200: no entry SHALL become valid, branch_cnt SHALL increment, and counter saturation at 32'hFFFFFFFF SHALL be checked via a forced preload.
